// File: rtl/word_mux4_pkg.sv
// Shared select encoding for the 4:1 word multiplexer.
// sel_i maps directly onto byte-offset bits [3:2] of the fetch address.
package word_mux4_pkg;

    typedef enum logic [1:0] {
        SelWord0 = 2'd0,
        SelWord1 = 2'd1,
        SelWord2 = 2'd2,
        SelWord3 = 2'd3
    } word_sel_e;

endpackage

// File: rtl/mux4_core.sv
// Combinational 4:1 word select. This path has no state, so it can feed the CPU in the same
// cycle as a cache hit.
module mux4_core
    import word_mux4_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = in0_i;
        // All four encodings are legal, so the case statement is complete.
        unique case (word_sel_e'(sel_i))
            SelWord0: out_o = in0_i;
            SelWord1: out_o = in1_i;
            SelWord2: out_o = in2_i;
            SelWord3: out_o = in3_i;
        endcase
    end

endmodule

// File: rtl/word_mux4.sv
// 4:1 word multiplexer with a combinational output and a one-cycle registered copy for callers
// that need a pipeline-stage boundary.
module word_mux4
    import word_mux4_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] out_q_o,
    output logic             valid_q_o
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    mux4_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .sel_i(sel_i),
        .in0_i(in0_i),
        .in1_i(in1_i),
        .in2_i(in2_i),
        .in3_i(in3_i),
        .out_o(out_o)
    );

    // The data register holds its last capture when idle; only the valid flag drops.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_i;
        if (valid_i) begin
            data_d = out_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_q_o   = data_q;
    assign valid_q_o = valid_q;

endmodule

// File: tb/tb_word_mux4.sv
// Self-checking bench for word_mux4: direct combinational checks plus a scoreboard of expected
// register-stage results pushed at drive time and popped one edge later.
module tb_word_mux4;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   sel;
    logic [W-1:0] in0, in1, in2, in3;
    logic         valid;
    logic [W-1:0] out_comb, out_reg;
    logic         valid_reg;

    always #5 clk = ~clk;

    word_mux4 #(
        .WIDTH(W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .sel_i    (sel),
        .in0_i    (in0),
        .in1_i    (in1),
        .in2_i    (in2),
        .in3_i    (in3),
        .valid_i  (valid),
        .out_o    (out_comb),
        .out_q_o  (out_reg),
        .valid_q_o(valid_reg)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         vld;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] m_data;
    logic         m_valid;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c,
                                          input logic [W-1:0] d);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    // Push the expected register state for the coming edge, clock once, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        if (rst) begin
            m_data  = '0;
            m_valid = 1'b0;
        end else if (valid) begin
            m_data  = pick(sel, in0, in1, in2, in3);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        sb_q.push_back('{data: m_data, vld: m_valid});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_out_q"}, out_reg, e.data);
            check_eq({tag, "_valid_q"}, {31'd0, valid_reg}, {31'd0, e.vld});
        end
    endtask

    initial begin
        logic [127:0] block;
        logic [3:0]   pc_off;

        rst   = 1'b1;
        valid = 1'b0;
        sel   = 2'd0;
        in0   = 32'h11111111;
        in1   = 32'h22222222;
        in2   = 32'h33333333;
        in3   = 32'h44444444;
        @(negedge clk);
        step("reset0");
        step("reset1");
        check_eq("reset_out_q_zero", out_reg, 32'h0);

        // Combinational sweep, no clock edge between changes.
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check_eq($sformatf("comb_sel%0d", s), out_comb, pick(sel, 32'h11111111,
                     32'h22222222, 32'h33333333, 32'h44444444));
        end

        valid = 1'b1;
        sel   = 2'd2;
        in2   = 32'hDEADBEEF;
        step("capture");
        check_eq("capture_const", out_reg, 32'hDEADBEEF);

        valid = 1'b0;
        sel   = 2'd0;
        in0   = 32'h0;
        #1;
        check_eq("hold_comb", out_comb, 32'h0);
        step("hold");
        check_eq("hold_const", out_reg, 32'hDEADBEEF);

        rst   = 1'b1;
        valid = 1'b1;
        sel   = 2'd3;
        in3   = 32'hCAFEF00D;
        #1;
        check_eq("rstprio_comb_pre", out_comb, 32'hCAFEF00D);
        step("rstprio");
        check_eq("rstprio_comb_post", out_comb, 32'hCAFEF00D);

        rst = 1'b0;
        in0 = 32'hA0A0A0A0;
        in1 = 32'hB1B1B1B1;
        in2 = 32'hC2C2C2C2;
        in3 = 32'hD3D3D3D3;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step($sformatf("b2b%0d", s));
        end
        valid = 1'b0;
        step("b2b_idle");

        block = 128'h44444444_33333333_22222222_11111111;
        in0   = block[31:0];
        in1   = block[63:32];
        in2   = block[95:64];
        in3   = block[127:96];
        for (int k = 0; k < 4; k++) begin
            pc_off = 4'(k * 4);
            sel    = pc_off[3:2];
            #1;
            check_eq($sformatf("slice_off%0h", pc_off), out_comb, block[k*32 +: 32]);
        end

        // Random traffic including mid-stream resets.
        for (int i = 0; i < 24; i++) begin
            rst   = ($urandom_range(0, 7) == 0);
            valid = $urandom_range(0, 1) == 1;
            sel   = 2'($urandom_range(0, 3));
            in0   = $urandom;
            in1   = $urandom;
            in2   = $urandom;
            in3   = $urandom;
            #1;
            check_eq($sformatf("rand_comb%0d", i), out_comb, pick(sel, in0, in1, in2, in3));
            step($sformatf("rand%0d", i));
        end

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
